// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs R/I/S/B/U/J fields into 32-bit words and buffers them in a FIFO.
// Latency 1 cycle from accept to out_valid; in_ready deasserts only when the FIFO is full.
module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_fmt,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic [6:0]                 in_funct7,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      enc_word;
  logic             fmt_ok;
  logic             imm_odd;
  logic             accept;
  logic             push;
  logic             pop;

  always_comb begin
    enc_word = '0;
    fmt_ok   = 1'b1;
    case (in_fmt)
      3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
      3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
      3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

  // B/J offsets are halfword-aligned; an odd offset is flagged but still encoded
  assign imm_odd   = ((in_fmt == 3'd3) || (in_fmt == 3'd5)) && in_imm[0];

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & fmt_ok;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_addr <= BASE;
      err      <= 2'b00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_addr <= out_addr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !fmt_ok) err[0] <= 1'b1;
      if (accept && imm_odd) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: queue-based reference model checked every cycle, directed cases plus random traffic.
module tb_inst_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [2:0]  count;
  logic [1:0]  err;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  int          maddr = 0;
  logic [1:0]  merr = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Field placement written as shifts/masks straight from the bit layout tables
  function automatic logic [31:0] enc(input int fmt, input logic [31:0] op, f3, f7, rd, rs1, rs2, imm);
    logic [31:0] w;
    w = op | (f3 << 12);
    case (fmt)
      0: w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      1: w = w | (rd << 7) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      2: w = w | ((imm & 32'h1F) << 7) | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 32'h7F) << 25);
      3: w = w | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | (rs1 << 15) | (rs2 << 20)
               | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
      4: w = op | (rd << 7) | (imm & 32'hFFFFF000);
      5: w = op | (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
               | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Reference model: occupancy is the queue length, pop before push within a cycle
  always @(posedge clk) begin
    bit acc;
    bit pp;
    if (!rst_n) begin
      mq.delete();
      maddr = 0;
      merr  = 2'b00;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && out_ready;
      if (pp) begin
        void'(mq.pop_front());
        maddr = (maddr + 1) % (1 << ADDR_W);
      end
      if (acc) begin
        if (in_fmt > 3'd5) merr[0] = 1'b1;
        else mq.push_back(enc(int'(in_fmt), 32'(in_opcode), 32'(in_funct3), 32'(in_funct7),
                              32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm));
        if ((in_fmt == 3'd3 || in_fmt == 3'd5) && in_imm[0]) merr[1] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_out_inst", out_inst, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("m_out_addr", 32'(out_addr), 32'(maddr));
      chk("m_err", 32'(err), 32'(merr));
    end
  end

  task automatic set_in(input int fmt, input int op, input int f3, input int f7,
                        input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    in_fmt = 3'(fmt); in_opcode = 7'(op); in_funct3 = 3'(f3); in_funct7 = 7'(f7);
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  task automatic send(input int fmt, input int op, input int f3, input int f7,
                      input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    int n;
    set_in(fmt, op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // add x3,x1,x2
    send(0, 'h33, 0, 0, 3, 1, 2, 32'h0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_inst", out_inst, 32'h002081B3);
    chk("add_addr", 32'(out_addr), 32'd0);

    // sub then addi back-to-back with consumer ready
    do_reset();
    out_ready = 1'b1;
    send(0, 'h33, 0, 'h20, 3, 1, 2, 32'h0);
    chk("sub_inst", out_inst, 32'h402081B3);
    chk("sub_addr", 32'(out_addr), 32'd0);
    send(1, 'h13, 0, 0, 5, 0, 0, 32'hFFFFFFFF);
    chk("addi_inst", out_inst, 32'hFFF00293);
    chk("addi_addr", 32'(out_addr), 32'd1);
    out_ready = 1'b0;

    // beq / jal
    do_reset();
    send(3, 'h63, 0, 0, 0, 1, 2, 32'd8);
    chk("beq_inst", out_inst, 32'h00208463);
    send(5, 'h6F, 0, 0, 1, 0, 0, 32'd2048);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("jal_inst", out_inst, 32'h001000EF);
    chk("bj_err", 32'(err), 32'd0);

    // fill to full, then pop while still offering
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 'h33, 0, 0, i, 0, 0, 32'h0);
    set_in(0, 'h33, 0, 0, 4, 0, 0, 32'h0);
    in_valid = 1'b1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_head", out_inst, 32'h000000B3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pushpop_count", 32'(count), 32'd3);
    repeat (4) @(negedge clk);
    out_ready = 1'b0;

    // illegal format drop, then odd B offset
    do_reset();
    send(6, 'h33, 0, 0, 1, 1, 1, 32'h0);
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    send(3, 'h63, 0, 0, 0, 1, 2, 32'd9);
    chk("odd_inst", out_inst, 32'h00208463);
    chk("odd_err", 32'(err), 32'd3);
    chk("odd_addr", 32'(out_addr), 32'd0);
    send(1, 'h13, 0, 0, 1, 0, 0, 32'd1);
    send(1, 'h13, 0, 0, 2, 0, 0, 32'd2);
    chk("mid_count", 32'(count), 32'd3);

    // reset mid-stream beats a concurrent handshake
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_addr", 32'(out_addr), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);

    // address wrap at 2^ADDR_W
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(4, 'h37, 0, 0, i, 0, 0, 32'(i) << 12);
      chk("wrap_addr", 32'(out_addr), 32'(i % 4));
    end
    out_ready = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 6);
      set_in($urandom_range(0, 7), $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
